// File: rtl/scoreboard_register_file_pkg.sv
// Architecture defaults shared by the scoreboarded register file, its bus interface and counters.
// Also provides the RF_ADDR_W(n) address-width macro.
`ifndef RF_ADDR_W
`define RF_ADDR_W(n) $clog2(n)
`endif

package scoreboard_register_file_pkg;

  localparam int RF_DATA_WIDTH = 16;
  localparam int RF_NUM_REGS   = 8;
  localparam int RF_NUM_READ   = 2;
  localparam int RF_PEND_MAX   = 3;

  // Counter width able to hold every value from 0 up to pend_max inclusive.
  function automatic int rf_cnt_w(input int pend_max);
    return $clog2(pend_max + 1);
  endfunction

endpackage

// File: rtl/scoreboard_register_file_if.sv
// Read / issue / write-back bus of the scoreboarded register file.
// master = pipeline side, slave = register file side.
interface scoreboard_register_file_if
  import scoreboard_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int NUM_READ   = RF_NUM_READ
);

  localparam int ADDR_W = `RF_ADDR_W(NUM_REGS);

  logic [NUM_READ*ADDR_W-1:0]     rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ-1:0]            rd_busy;
  logic                           issue_valid;
  logic [ADDR_W-1:0]              issue_addr;
  logic                           issue_ready;
  logic                           wr_en;
  logic [ADDR_W-1:0]              wr_addr;
  logic [DATA_WIDTH-1:0]          wr_data;
  logic                           pending_any;
  logic                           sb_underflow;

  modport master (
    output rd_addr, issue_valid, issue_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_busy, issue_ready, pending_any, sb_underflow
  );

  modport slave (
    input  rd_addr, issue_valid, issue_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_busy, issue_ready, pending_any, sb_underflow
  );

endinterface

// File: rtl/scoreboard_register_file_sb_counter.sv
// sb_counter: one register's pending-write counter, saturating at 'max' and floored at zero.
// 'underflow' flags a decrement request that arrived while the count was already zero.
module sb_counter
  import scoreboard_register_file_pkg::*;
#(
  parameter int PEND_MAX = RF_PEND_MAX,
  parameter int CNT_W    = rf_cnt_w(PEND_MAX)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic [CNT_W-1:0] max,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             at_max,
  output logic             underflow
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             inc_s;

  // Next count: an issue and a write-back on the same register cancel out.
  always_comb begin
    inc_s = inc && (count_r != max);
    if (inc_s && dec) begin
      count_nxt_s = count_r;
    end else if (inc_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (dec && (count_r != '0)) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count     = count_r;
  assign nonzero   = (count_r != '0);
  assign at_max    = (count_r == max);
  assign underflow = dec && (count_r == '0);

endmodule

// File: rtl/scoreboard_register_file.sv
// Multi-port register file with a per-register pending-write scoreboard for RAW hazard stalls.
// Optional RF_BYPASS_EN: forwards same-cycle write-back data and clears busy on the final write-back.
module scoreboard_register_file
  import scoreboard_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int NUM_READ   = RF_NUM_READ,
  parameter int PEND_MAX   = RF_PEND_MAX
) (
  input logic                        clock,
  input logic                        reset,
  scoreboard_register_file_if.slave  bus
);

  localparam int ADDR_W = `RF_ADDR_W(NUM_REGS);
  localparam int CNT_W  = rf_cnt_w(PEND_MAX);

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic [CNT_W-1:0]      count_s [NUM_REGS];
  logic [NUM_REGS-1:0]   nonzero_s;
  logic [NUM_REGS-1:0]   at_max_s;
  logic [NUM_REGS-1:0]   underflow_s;
  logic                  sb_underflow_r;
  logic                  issue_ready_s;
  logic                  issue_fire_s;
  logic [DATA_WIDTH-1:0] port_data_s [NUM_READ];
  logic                  port_busy_s [NUM_READ];

  // Register array write-back port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= '0;
      end
    end else if (bus.wr_en) begin
      regs_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_underflow_r <= 1'b0;
    end else if (|underflow_s) begin
      sb_underflow_r <= 1'b1;
    end
  end

  // Issue acceptance deliberately ignores a same-cycle write-back to the same register.
  always_comb begin
    issue_ready_s = !at_max_s[bus.issue_addr];
    issue_fire_s  = bus.issue_valid && issue_ready_s;
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    logic inc_s;
    logic dec_s;

    // Per-register increment/decrement decode.
    always_comb begin
      inc_s = issue_fire_s && (bus.issue_addr == ADDR_W'(r));
      dec_s = bus.wr_en && (bus.wr_addr == ADDR_W'(r));
    end

    sb_counter #(
      .PEND_MAX (PEND_MAX),
      .CNT_W    (CNT_W)
    ) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .inc       (inc_s),
      .dec       (dec_s),
      .max       (CNT_W'(PEND_MAX)),
      .count     (count_s[r]),
      .nonzero   (nonzero_s[r]),
      .at_max    (at_max_s[r]),
      .underflow (underflow_s[r])
    );
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0]     addr_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  busy_s;
`ifdef RF_BYPASS_EN
    logic                  hit_s;
    logic                  clear_s;
`endif

    // Read mux; the bypass is held off during reset so outputs read zero.
    always_comb begin
      addr_s = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
      hit_s   = bus.wr_en && (bus.wr_addr == addr_s) && !reset;
      clear_s = hit_s && (count_s[addr_s] == CNT_W'(1)) &&
                !(issue_fire_s && (bus.issue_addr == addr_s));
      if (hit_s) begin
        data_s = bus.wr_data;
      end else begin
        data_s = regs_r[addr_s];
      end
      busy_s = (count_s[addr_s] != '0) && !clear_s;
`else
      data_s = regs_r[addr_s];
      busy_s = (count_s[addr_s] != '0);
`endif
    end

    assign port_data_s[i] = data_s;
    assign port_busy_s[i] = busy_s;
  end

  // Pack per-port results onto the bus.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = port_data_s[i];
      bus.rd_busy[i]                          = port_busy_s[i];
    end
  end

  assign bus.issue_ready  = issue_ready_s;
  assign bus.pending_any  = |nonzero_s;
  assign bus.sb_underflow = sb_underflow_r;

endmodule
